shot_sequencer: RTL



---
 rtl/shot_seq_pkg.sv | 31 +++
 rtl/sof_counter.sv | 31 +++
 rtl/shot_sequencer.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/shot_seq_pkg.sv
// Shared types and defaults for the cue-shot sequencer.
package shot_seq_pkg;

  localparam int unsigned COUNT_W = 8;
  localparam int unsigned VEL_W   = 32;

  localparam int unsigned DEF_SETTLE_FRAMES     = 30;
  localparam int unsigned DEF_MAX_CHARGE_FRAMES = 100;
  localparam int unsigned DEF_STRIKE_FRAMES     = 4;
  localparam int unsigned DEF_ROLL_TIMEOUT      = 30;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WAIT_STILL = 3'd1,
    AIM        = 3'd2,
    CHARGE     = 3'd3,
    STRIKE     = 3'd4,
    ROLLING    = 3'd5
  } shot_state_t;

  typedef struct packed {
    logic signed [VEL_W-1:0] x;
    logic signed [VEL_W-1:0] y;
  } shot_vel_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
    return (v == '1) ? v : v + COUNT_W'(1);
  endfunction

endpackage

// File: rtl/sof_counter.sv
// Frame-gated up-counter with synchronous clear and a terminal-value flag.
module sof_counter
  import shot_seq_pkg::*;
#(
  parameter int unsigned TERMINAL = 0,
  parameter bit          SATURATE = 1'b1
) (
  input  logic clk,
  input  logic resetN,
  input  logic sof,
  input  logic clear,
  input  logic enable,
  output logic at_term_c
);

  logic [COUNT_W-1:0] count;

  // Clear is not frame-gated so the owner can flush on any clock.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (sof && enable) begin
      count <= SATURATE ? sat_inc(count) : count + COUNT_W'(1);
    end
  end

  assign at_term_c = (count == COUNT_W'(TERMINAL));

endmodule

// File: rtl/shot_sequencer.sv
// Per-frame cue shot sequencer: settle, aim, charge, strike, fire, roll; owns turn and shot count.
module shot_sequencer
  import shot_seq_pkg::*;
#(
  parameter int unsigned SETTLE_FRAMES     = DEF_SETTLE_FRAMES,
  parameter int unsigned MAX_CHARGE_FRAMES = DEF_MAX_CHARGE_FRAMES,
  parameter int unsigned STRIKE_FRAMES     = DEF_STRIKE_FRAMES,
  parameter int unsigned ROLL_TIMEOUT      = DEF_ROLL_TIMEOUT
) (
  input  logic                    clk,
  input  logic                    resetN,
  input  logic                    startOfFrame,
  input  logic                    space_pressed,
  input  logic                    game_state,
  input  logic                    no_moving_flag,
  input  logic signed [VEL_W-1:0] stick_velocityX,
  input  logic signed [VEL_W-1:0] stick_velocityY,
  output logic                    shot_fire,
  output logic signed [VEL_W-1:0] shotVelocityX,
  output logic signed [VEL_W-1:0] shotVelocityY,
  output logic                    aim_enable,
  output logic                    stick_visible,
  output logic [COUNT_W-1:0]      charge_level,
  output logic                    current_player,
  output logic [COUNT_W-1:0]      shot_count,
  output logic [2:0]              state_dbg
);

  localparam logic [COUNT_W-1:0] CHARGE_MAX = COUNT_W'(MAX_CHARGE_FRAMES);

  shot_state_t state;
  shot_vel_t   shot_vel;

  logic settle_term_c, strike_term_c, roll_term_c;
  logic settle_en, settle_clr;
  logic strike_en, strike_clr;
  logic roll_en, roll_clr;

  // Counters run only in their own state and flush on every exit path.
  assign settle_en  = (state == WAIT_STILL) && no_moving_flag;
  assign settle_clr = !game_state || (state != WAIT_STILL) ||
                      (startOfFrame && (!no_moving_flag || settle_term_c));

  assign strike_en  = (state == STRIKE);
  assign strike_clr = !game_state || (state != STRIKE) ||
                      (startOfFrame && strike_term_c);

  assign roll_en    = (state == ROLLING);
  assign roll_clr   = !game_state || (state != ROLLING) ||
                      (startOfFrame && (!no_moving_flag || roll_term_c));

  sof_counter #(.TERMINAL(SETTLE_FRAMES - 1), .SATURATE(1'b1)) u_settle_cnt (
    .clk       (clk),
    .resetN    (resetN),
    .sof       (startOfFrame),
    .clear     (settle_clr),
    .enable    (settle_en),
    .at_term_c (settle_term_c)
  );

  sof_counter #(.TERMINAL(STRIKE_FRAMES - 1), .SATURATE(1'b1)) u_strike_cnt (
    .clk       (clk),
    .resetN    (resetN),
    .sof       (startOfFrame),
    .clear     (strike_clr),
    .enable    (strike_en),
    .at_term_c (strike_term_c)
  );

  sof_counter #(.TERMINAL(ROLL_TIMEOUT - 1), .SATURATE(1'b1)) u_roll_cnt (
    .clk       (clk),
    .resetN    (resetN),
    .sof       (startOfFrame),
    .clear     (roll_clr),
    .enable    (roll_en),
    .at_term_c (roll_term_c)
  );

  // Shot FSM with registered outputs; leaving the game overrides frame timing.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      state          <= IDLE;
      shot_fire      <= 1'b0;
      shot_vel       <= '0;
      aim_enable     <= 1'b0;
      stick_visible  <= 1'b0;
      charge_level   <= '0;
      current_player <= 1'b0;
      shot_count     <= '0;
    end else if (!game_state) begin
      state          <= IDLE;
      shot_fire      <= 1'b0;
      shot_vel       <= '0;
      aim_enable     <= 1'b0;
      stick_visible  <= 1'b0;
      charge_level   <= '0;
      current_player <= 1'b0;
    end else begin
      shot_fire <= 1'b0;
      if (startOfFrame) begin
        unique case (state)
          IDLE: begin
            state <= WAIT_STILL;
          end
          WAIT_STILL: begin
            if (no_moving_flag && settle_term_c) begin
              state         <= AIM;
              aim_enable    <= 1'b1;
              stick_visible <= 1'b1;
              charge_level  <= '0;
            end
          end
          AIM: begin
            if (!no_moving_flag) begin
              state         <= WAIT_STILL;
              aim_enable    <= 1'b0;
              stick_visible <= 1'b0;
            end else if (space_pressed) begin
              state        <= CHARGE;
              charge_level <= COUNT_W'(1);
            end
          end
          CHARGE: begin
            // Release and max charge on the same frame collapse into one strike.
            if (!space_pressed || (charge_level == CHARGE_MAX)) begin
              state      <= STRIKE;
              aim_enable <= 1'b0;
              shot_vel.x <= stick_velocityX;
              shot_vel.y <= stick_velocityY;
            end else begin
              charge_level <= sat_inc(charge_level);
            end
          end
          STRIKE: begin
            if (strike_term_c) begin
              state         <= ROLLING;
              shot_fire     <= 1'b1;
              shot_count    <= shot_count + COUNT_W'(1);
              stick_visible <= 1'b0;
            end
          end
          ROLLING: begin
            if (!no_moving_flag || roll_term_c) begin
              state          <= WAIT_STILL;
              current_player <= ~current_player;
            end
          end
          default: begin
            state         <= IDLE;
            aim_enable    <= 1'b0;
            stick_visible <= 1'b0;
          end
        endcase
      end
    end
  end

  assign shotVelocityX = shot_vel.x;
  assign shotVelocityY = shot_vel.y;
  assign state_dbg     = state;

endmodule
